// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and
// the helper that places stage registers between barrel levels.
package shift_pkg;

  typedef logic [2:0] func_t;

  localparam func_t FN_ZERO = 3'b000;
  localparam func_t FN_SLL  = 3'b001;
  localparam func_t FN_SRL  = 3'b010;
  localparam func_t FN_SRA  = 3'b011;
  localparam func_t FN_ROL  = 3'b100;
  localparam func_t FN_ROR  = 3'b101;

  // True when barrel level 'level' is the last level of a pipeline stage.
  // Levels are split as evenly as possible; earlier stages take the extra one.
  function automatic logic stage_boundary(input int level, input int saw, input int lat);
    int   acc;
    logic hit;
    acc = 0;
    hit = 1'b0;
    for (int s = 0; s < lat; s++) begin
      acc = acc + (saw / lat) + ((s < (saw % lat)) ? 1 : 0);
      if (acc == level + 1) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: conditionally moves the operand by DIST.
// Rotates exist only when SHIFT_PIPE_ROTATE_EN is defined; otherwise the
// rotate codes yield zero and no rotate muxing is built.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  func_t            func,
  output logic [WIDTH-1:0] result
);

  // Select the moved or unmoved operand for this level according to func.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (func)
      FN_SLL: begin
        if (enable) begin
          result = {data[WIDTH-1-DIST:0], {DIST{1'b0}}};
        end else begin
          result = data;
        end
      end
      FN_SRL: begin
        if (enable) begin
          result = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
        end else begin
          result = data;
        end
      end
      FN_SRA: begin
        // Earlier levels keep the MSB intact, so data[WIDTH-1] is the original sign.
        if (enable) begin
          result = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
        end else begin
          result = data;
        end
      end
`ifdef SHIFT_PIPE_ROTATE_EN
      FN_ROL: begin
        if (enable) begin
          result = {data[WIDTH-1-DIST:0], data[WIDTH-1:WIDTH-DIST]};
        end else begin
          result = data;
        end
      end
      FN_ROR: begin
        if (enable) begin
          result = {data[DIST-1:0], data[WIDTH-1:DIST]};
        end else begin
          result = data;
        end
      end
`endif
      default: begin
        result = {WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter for the execute stage. SAW barrel levels are split
// over LATENCY register stages (the last stage is the output register) with a
// global stall whenever the output is valid but not accepted.
// Optional rotates: define SHIFT_PIPE_ROTATE_EN.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SAW     = $clog2(WIDTH),
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SAW-1:0]   in_shamt,
  input  logic [2:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  // Per-level inputs (operand and sideband) and per-level results.
  logic [WIDTH-1:0] lvl_data_s  [SAW];
  logic [WIDTH-1:0] lvl_res_s   [SAW];
  logic [SAW-1:0]   lvl_shamt_s [SAW];
  func_t            lvl_func_s  [SAW];
  logic [TAG_W-1:0] lvl_tag_s   [SAW];
  logic             lvl_valid_s [SAW];

  logic             stall_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             out_zero_r;

  assign stall_s  = out_valid_r & ~out_ready;
  assign in_ready = ~stall_s;

  assign lvl_data_s[0]  = in_data;
  assign lvl_shamt_s[0] = in_shamt;
  assign lvl_func_s[0]  = in_func;
  assign lvl_tag_s[0]   = in_tag;
  assign lvl_valid_s[0] = in_valid;

  for (genvar k = 0; k < SAW; k++) begin : g_level
    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_level (
      .data   (lvl_data_s[k]),
      .enable (lvl_shamt_s[k][k]),
      .func   (lvl_func_s[k]),
      .result (lvl_res_s[k])
    );

    if (k < SAW - 1) begin : g_link
      if (stage_boundary(k, SAW, LATENCY)) begin : g_reg
        logic [WIDTH-1:0] data_r;
        logic [SAW-1:0]   shamt_r;
        func_t            func_r;
        logic [TAG_W-1:0] tag_r;
        logic             valid_r;

        // Intermediate stage register; holds everything while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            shamt_r <= {SAW{1'b0}};
            func_r  <= FN_ZERO;
            tag_r   <= {TAG_W{1'b0}};
            valid_r <= 1'b0;
          end else if (!stall_s) begin
            data_r  <= lvl_res_s[k];
            shamt_r <= lvl_shamt_s[k];
            func_r  <= lvl_func_s[k];
            tag_r   <= lvl_tag_s[k];
            valid_r <= lvl_valid_s[k];
          end
        end

        assign lvl_data_s[k+1]  = data_r;
        assign lvl_shamt_s[k+1] = shamt_r;
        assign lvl_func_s[k+1]  = func_r;
        assign lvl_tag_s[k+1]   = tag_r;
        assign lvl_valid_s[k+1] = valid_r;
      end else begin : g_wire
        assign lvl_data_s[k+1]  = lvl_res_s[k];
        assign lvl_shamt_s[k+1] = lvl_shamt_s[k];
        assign lvl_func_s[k+1]  = lvl_func_s[k];
        assign lvl_tag_s[k+1]   = lvl_tag_s[k];
        assign lvl_valid_s[k+1] = lvl_valid_s[k];
      end
    end
  end

  // Output register; zero flag is derived from the final level before registering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      out_zero_r  <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= lvl_valid_s[SAW-1];
      out_data_r  <= lvl_res_s[SAW-1];
      out_tag_r   <= lvl_tag_s[SAW-1];
      out_zero_r  <= (lvl_res_s[SAW-1] == {WIDTH{1'b0}});
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_tag   = out_tag_r;
  assign out_zero  = out_zero_r;

endmodule
